// File: rtl/fp_align_shift_if.sv
// Handshake and operand bus for the FP pre-add alignment stage.
// The producer drives operands and out_ready. The alignment block (slave) returns
// the ordered and aligned result.
interface fp_align_shift_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  exp_a;
  logic [MANT_W-1:0] mant_a;
  logic [EXP_W-1:0]  exp_b;
  logic [MANT_W-1:0] mant_b;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_big;
  logic [MANT_W-1:0] mant_small;
  logic [2:0]        grs;
  logic              swapped;

  modport master (
    output in_valid, exp_a, mant_a, exp_b, mant_b, out_ready,
    input  in_ready, out_valid, exp_out, mant_big, mant_small, grs, swapped
  );

  modport slave (
    input  in_valid, exp_a, mant_a, exp_b, mant_b, out_ready,
    output in_ready, out_valid, exp_out, mant_big, mant_small, grs, swapped
  );
endinterface

// File: rtl/fp_align_shift.sv
// fp_align_shift: pre-add alignment stage of the FP adder.
// The block orders the two operands by magnitude. It then shifts the smaller
// mantissa right by the exponent difference, at most STEP bits per cycle. It
// also produces the guard, round and sticky bits.
// Optional macro FP_ALIGN_STICKY_EN enables sticky collection. When the macro
// is not defined, grs[0] is always 0.
module fp_align_shift #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int STEP   = 4
) (
  input logic             clk,
  input logic             rst_n,
  fp_align_shift_if.slave bus
);

  localparam int W2 = MANT_W + 2;
  localparam int RW = $clog2(W2 + 1);
  localparam logic [EXP_W:0]  CLAMP  = (EXP_W+1)'(W2);
  localparam logic [RW-1:0]   STEP_R = RW'(STEP);
  localparam logic [RW-1:0]   CLAMP_R = RW'(W2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  logic [EXP_W-1:0]  exp_r;
  logic [MANT_W-1:0] big_r;
  logic [MANT_W-1:0] small_r;
  logic              g_r, r_r, s_r, sw_r;
  logic [RW-1:0]     rem_r;

  logic              accept;
  logic              swap;
  logic [EXP_W-1:0]  exp_big, exp_small;
  logic [MANT_W-1:0] mant_big_sel, mant_small_sel;
  logic [EXP_W:0]    diff;
  logic [RW-1:0]     rem_load;
  logic [RW-1:0]     k;
  logic [W2-1:0]     sr, sr_nxt;
`ifdef FP_ALIGN_STICKY_EN
  logic              clamped;
  logic [2*W2-1:0]   wide;
  logic              pushed;
`endif

  assign accept = (state == IDLE) && bus.in_valid;

  // Operand ordering and the shift count, evaluated for the accept edge
  always_comb begin
    swap = (bus.exp_b > bus.exp_a) ||
           ((bus.exp_b == bus.exp_a) && (bus.mant_b > bus.mant_a));
    exp_big        = swap ? bus.exp_b  : bus.exp_a;
    exp_small      = swap ? bus.exp_a  : bus.exp_b;
    mant_big_sel   = swap ? bus.mant_b : bus.mant_a;
    mant_small_sel = swap ? bus.mant_a : bus.mant_b;
    diff           = {1'b0, exp_big} - {1'b0, exp_small};
    rem_load       = (diff > CLAMP) ? CLAMP_R : RW'(diff);
  end

  // One shift step on {mant_small, G, R}. Bits below R fold into sticky
  always_comb begin
    k  = (rem_r < STEP_R) ? rem_r : STEP_R;
    sr = {small_r, g_r, r_r};
`ifdef FP_ALIGN_STICKY_EN
    clamped = (diff > CLAMP);
    // The low half of the double-width shift holds exactly the bits pushed past R
    wide    = {sr, {W2{1'b0}}} >> k;
    sr_nxt  = wide[2*W2-1:W2];
    pushed  = |wide[W2-1:0];
`else
    sr_nxt  = sr >> k;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = (rem_load != '0) ? SHIFT : DONE;
      SHIFT:   if (rem_r <= STEP_R) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Datapath registers: load at accept, shift in SHIFT, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r   <= '0;
      big_r   <= '0;
      small_r <= '0;
      g_r     <= 1'b0;
      r_r     <= 1'b0;
      s_r     <= 1'b0;
      sw_r    <= 1'b0;
      rem_r   <= '0;
    end else if (accept) begin
      exp_r   <= exp_big;
      big_r   <= mant_big_sel;
      small_r <= mant_small_sel;
      g_r     <= 1'b0;
      r_r     <= 1'b0;
`ifdef FP_ALIGN_STICKY_EN
      s_r     <= clamped & (|mant_small_sel);
`else
      s_r     <= 1'b0;
`endif
      sw_r    <= swap;
      rem_r   <= rem_load;
    end else if (state == SHIFT) begin
      {small_r, g_r, r_r} <= sr_nxt;
`ifdef FP_ALIGN_STICKY_EN
      s_r     <= s_r | pushed;
`else
      s_r     <= 1'b0;
`endif
      rem_r   <= rem_r - k;
    end
  end

  assign bus.exp_out    = exp_r;
  assign bus.mant_big   = big_r;
  assign bus.mant_small = small_r;
  assign bus.grs        = {g_r, r_r, s_r};
  assign bus.swapped    = sw_r;

endmodule
